// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler:
// command codes, issue FSM states and the illegal-code test.
package lcd_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE      = 4'h0;
  localparam logic [CMD_W-1:0] CMD_LAST_LEGAL = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } sched_state_t;

  function automatic logic cmd_illegal(input logic [CMD_W-1:0] c);
    return c > CMD_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command queue between the arbiter and the issue FSM.
// Push while full is honoured only when a pop happens in the same cycle.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rp];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= next_ptr(r_wp);
      if (w_pop)  r_rp <= next_ptr(r_rp);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Round-robin arbiter, illegal-code filter and issue FSM sharing
// the LCD controller command port between two requesters.
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [CMD_W-1:0] req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [CMD_W-1:0] req1_cmd,
  output logic             req1_ready,
  output logic [CMD_W-1:0] lcd_cmd,
  output logic             lcd_cmd_valid,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic             sched_idle,
  output logic             finished,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [7:0]       issued_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  sched_state_t     r_state;
  logic [CMD_W-1:0] r_lcd_cmd;
  logic             r_cmd_valid;
  logic             r_last_grant;
  logic             r_closed;
  logic             r_sched_idle;
  logic             r_finished;
  logic             r_err_illegal;
  logic             r_err_timeout;
  logic [7:0]       r_issued_cnt;
  logic [TW-1:0]    r_timer;

  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [CMD_W-1:0] w_head;
  logic             w_can;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_acc;
  logic [CMD_W-1:0] w_acc_cmd;
  logic             w_push;
  logic             w_pop;

  // On a tie the requester that did not win last time is granted.
  assign w_can     = !w_full && !r_closed;
  assign w_pick1   = req1_valid && (!req0_valid || !r_last_grant);
  assign w_pick0   = req0_valid && !w_pick1;
  assign req0_ready = w_can && w_pick0;
  assign req1_ready = w_can && w_pick1;

  assign w_acc     = req0_ready || req1_ready;
  assign w_acc_cmd = req1_ready ? req1_cmd : req0_cmd;
  assign w_push    = w_acc && !cmd_illegal(w_acc_cmd);
  assign w_pop     = (r_state == S_IDLE) && !w_empty &&
                     !lcd_busy && !r_finished;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_acc_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant  <= 1'b1;
      r_closed      <= 1'b0;
      r_err_illegal <= 1'b0;
      r_sched_idle  <= 1'b0;
    end else begin
      r_err_illegal <= w_acc && cmd_illegal(w_acc_cmd);
      r_sched_idle  <= (r_state == S_IDLE) && (w_count == '0);
      if (w_acc) r_last_grant <= req1_ready;
      if (w_acc && (w_acc_cmd == CMD_WRITE)) r_closed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lcd_cmd     <= '0;
      r_cmd_valid   <= 1'b0;
      r_finished    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_issued_cnt  <= '0;
      r_timer       <= '0;
    end else begin
      r_err_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_lcd_cmd   <= w_head;
            r_cmd_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cmd_valid  <= 1'b0;
          r_issued_cnt <= r_issued_cnt + 1'b1;
          r_timer      <= '0;
          r_state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (lcd_busy) begin
            r_state <= (r_lcd_cmd == CMD_WRITE) ? S_WAIT_DONE : S_IDLE;
          end else if (r_timer == TW'(BUSY_TIMEOUT - 1)) begin
            // Controller never acknowledged: the command is dropped.
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (lcd_done) begin
            r_finished <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lcd_cmd       = r_lcd_cmd;
  assign lcd_cmd_valid = r_cmd_valid;
  assign sched_idle    = r_sched_idle;
  assign finished      = r_finished;
  assign err_illegal   = r_err_illegal;
  assign err_timeout   = r_err_timeout;
  assign issued_cnt    = r_issued_cnt;

endmodule
